fadd_seq: RTL and testbench
===========================

Name: fadd_seq

Overview:
- Multi-cycle floating-point add/subtract unit producing unnormalized results for the downstream combinational normalizer.
- Word format is {sign, exp, man}:
  - exp is EXP-bit two's complement.
  - man is an MAN-bit unsigned integer with no hidden bit.
  - value = (-1)^sign * man * 2^exp.
  - Zero is man==0 with exp = 1 followed by EXP-1 zeros (most negative).
- Alignment is iterative, one bit per cycle, to keep area minimal.
- Uses valid/ready handshakes on both input and output sides.

Parameters:
- MAN, 23, mantissa width in bits
- EXP, 8, exponent width in bits (signed)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  operands/op valid
- in_ready  out  1  unit idle; accepts when in_valid&in_ready
- op  in  1  0 = a+b, 1 = a-b (sign of b inverted on accept)
- a  in  MAN+EXP+1  operand A {s,e,m}
- b  in  MAN+EXP+1  operand B {s,e,m}
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result when out_valid&out_ready
- out  out  MAN+EXP+1  unnormalized result {s,e,m}
- ovf  out  1  exponent saturation occurred for the current result (qualified by out_valid)

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; in_ready=1; out_valid=0; out=0; ovf=0.
  - All internal registers are cleared.
  - Reset mid-operation aborts and discards the operation.
- States: IDLE, ALIGN, ADD, HOLD.
- IDLE:
  - in_ready=1.
  - On accept, latch the operands with b.sign^op.
  - Order the operands so that the larger exponent is L and the smaller is S. On equal exponents, L=a.
  - d = eL-eS, computed in EXP+1 signed bits and treated as unsigned. cnt = min(d, MAN).
  - Next state ALIGN.
- ALIGN:
  - Each cycle with cnt>0: S.man >>= 1 (zero fill, shifted-out bits dropped, truncation); cnt -= 1.
  - When cnt==0, the next state is ADD.
- ADD, one cycle, MAN+1-bit magnitude arithmetic:
  - Same signs: sum = L.man+S.man, sign = L.sign.
    - If the carry bit is set: man = sum[MAN:1], exp = eL+1.
    - Otherwise: man = sum[MAN-1:0], exp = eL.
  - Different signs: subtract the smaller magnitude from the larger; sign = sign of the larger magnitude. Equal magnitudes give a zero result. exp = eL.
  - Exponent overflow (carry with eL = max positive): exp = max positive, man = all ones, ovf = 1.
  - Zero result (man==0): sign = 0, exp = 100..0.
  - Register the result into out; out_valid=1; next state HOLD.
- HOLD:
  - out and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid=0, next state IDLE. The next operand is accepted no earlier than the following cycle.
  - out retains its last value after the handshake; ovf is cleared on the next accept.
- Latency:
  - Accept at edge k gives out_valid high after edge k+cnt+2.
  - Best case is 2 cycles (d=0). Worst case is MAN+2 cycles.
- Zero operands need no special path. Their most-negative exponent drives cnt to MAN, which zeroes S.
- in_ready=0 in ALIGN, ADD and HOLD. Inputs are ignored there; no queueing.
- The output is never normalized here: leading zeros are allowed. Downstream normalization is the consumer's job.

Test Plan:
- Equal-exponent add with carry: MAN=23, EXP=8, a = b = {0,0xEA,0x400000} (1.0), op=0 -> after 2 cycles out={0,0xEB,0x400000}, ovf=0.
- Subtract with unnormalized result: a = {0,0xEA,0x400000}, b = {0,0xE9,0x400000} (0.5), op=1 -> cnt=1; after 3 cycles out={0,0xEA,0x200000}.
- Large exponent gap / cnt cap:
  - a = 1.0, b = {0,0xC2,0x400000} (d=40), op=0 -> cnt=23; after 25 cycles out = a exactly.
  - b = zero word -> same result and latency.
- Cancellation: a = b = 1.0, op=1 -> out={0,0x80,0x000000}.
- Sign handling: a = {1,0xEA,0x400000}, b = {0,0xEA,0x100000}, op=0 -> out={1,0xEA,0x300000}.
- Saturation, backpressure and reset:
  - a = b = {0,0x7F,0x7FFFFF}, op=0 -> out={0,0x7F,0x7FFFFF} with ovf=1.
  - Hold out_ready=0 for 5 cycles -> out and out_valid stable, in_ready=0.
  - Separately, assert rst=0 during ALIGN of a d=10 op -> immediate in_ready=1, out_valid=0, out=0. The next operation completes normally.

Source files
------------

// File: rtl/fadd_seq.sv
// Multi-cycle floating-point add/subtract with unnormalized output.
// Alignment shifts the smaller operand one bit per cycle; a combinational normalizer sits downstream.
module fadd_seq #(
    parameter int MAN = 23,
    parameter int EXP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [MAN+EXP:0] a,
    input  logic [MAN+EXP:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN+EXP:0] out,
    output logic             ovf
);
    // Handshakes: a word moves only on a clock edge where valid & ready are both high;
    // out_valid and out stay put until taken, and inputs are ignored while in_ready is low.
    localparam int CW = $clog2(MAN + 1);
    localparam logic [EXP-1:0] EXP_MAX  = {1'b0, {(EXP-1){1'b1}}};
    localparam logic [EXP-1:0] EXP_ZERO = {1'b1, {(EXP-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, HOLD} state_t;
    state_t state;

    logic           l_sign, s_sign;
    logic [EXP-1:0] l_exp;
    logic [MAN-1:0] l_man, s_man;
    logic [CW-1:0]  cnt;

    logic           a_sign, b_sign, a_ge;
    logic [EXP-1:0] a_exp, b_exp;
    logic [MAN-1:0] a_man, b_man;
    logic [EXP:0]   diff;
    logic [CW-1:0]  cnt_init;

    assign a_sign = a[MAN+EXP];
    assign b_sign = b[MAN+EXP] ^ op;
    assign a_exp  = a[MAN+EXP-1:MAN];
    assign b_exp  = b[MAN+EXP-1:MAN];
    assign a_man  = a[MAN-1:0];
    assign b_man  = b[MAN-1:0];
    assign a_ge   = $signed(a_exp) >= $signed(b_exp);

    // Exponent gap in EXP+1 bits so the full signed range cannot wrap.
    always_comb begin
        if (a_ge) diff = {a_exp[EXP-1], a_exp} - {b_exp[EXP-1], b_exp};
        else      diff = {b_exp[EXP-1], b_exp} - {a_exp[EXP-1], a_exp};
        if (32'(diff) > 32'(MAN)) cnt_init = CW'(MAN);
        else                      cnt_init = CW'(diff);
    end

    logic [MAN:0]   sum;
    logic           l_big;
    logic [MAN-1:0] sub_man;
    logic           res_sign, res_ovf;
    logic [EXP-1:0] res_exp;
    logic [MAN-1:0] res_man;

    assign sum     = {1'b0, l_man} + {1'b0, s_man};
    assign l_big   = l_man >= s_man;
    assign sub_man = l_big ? (l_man - s_man) : (s_man - l_man);

    always_comb begin
        res_sign = l_sign;
        res_exp  = l_exp;
        res_man  = '0;
        res_ovf  = 1'b0;
        if (l_sign == s_sign) begin
            if (sum[MAN]) begin
                if (l_exp == EXP_MAX) begin
                    res_man = '1;
                    res_ovf = 1'b1;
                end else begin
                    res_man = sum[MAN:1];
                    res_exp = l_exp + 1'b1;
                end
            end else begin
                res_man = sum[MAN-1:0];
            end
        end else begin
            res_man  = sub_man;
            res_sign = l_big ? l_sign : s_sign;
        end
        if (res_man == '0) begin
            res_sign = 1'b0;
            res_exp  = EXP_ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
            l_sign    <= 1'b0;
            s_sign    <= 1'b0;
            l_exp     <= '0;
            l_man     <= '0;
            s_man     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        l_sign   <= a_ge ? a_sign : b_sign;
                        l_exp    <= a_ge ? a_exp  : b_exp;
                        l_man    <= a_ge ? a_man  : b_man;
                        s_sign   <= a_ge ? b_sign : a_sign;
                        s_man    <= a_ge ? b_man  : a_man;
                        cnt      <= cnt_init;
                        ovf      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (cnt != '0) begin
                        s_man <= s_man >> 1;
                        cnt   <= cnt - 1'b1;
                    end else begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    out       <= {res_sign, res_exp, res_man};
                    ovf       <= res_ovf;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fadd_seq.sv
// Self-checking bench for fadd_seq: integer reference model, expected queue and per-cycle output monitor.
module tb_fadd_seq;
    localparam int MAN = 23;
    localparam int EXP = 8;
    localparam int W   = MAN + EXP + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         op = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, ovf;
    logic [W-1:0] out;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic         ovf_q[$];

    fadd_seq #(.MAN(MAN), .EXP(EXP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic s, input logic [EXP-1:0] e, input logic [MAN-1:0] m);
        return {s, e, m};
    endfunction

    // Reference: value = (-1)^s * m * 2^e, evaluated with plain integer arithmetic.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                                  output logic [W-1:0] r, output logic r_ovf, output int lat);
        int xe, ye, le, se, lm, sm, d, cnt, m, e;
        logic xs, ys, ls, ss, s;
        logic [EXP-1:0] ev;
        logic [MAN-1:0] mv;
        xs = x[W-1];
        ys = y[W-1] ^ o;
        xe = int'($signed(x[W-2:MAN]));
        ye = int'($signed(y[W-2:MAN]));
        if (xe >= ye) begin
            ls = xs; le = xe; lm = int'(x[MAN-1:0]);
            ss = ys; se = ye; sm = int'(y[MAN-1:0]);
        end else begin
            ls = ys; le = ye; lm = int'(y[MAN-1:0]);
            ss = xs; se = xe; sm = int'(x[MAN-1:0]);
        end
        d   = le - se;
        cnt = (d > MAN) ? MAN : d;
        sm  = sm / (1 << cnt);
        r_ovf = 1'b0;
        s = ls;
        e = le;
        if (ls == ss) begin
            m = lm + sm;
            if (m >= (1 << MAN)) begin
                if (le == (1 << (EXP - 1)) - 1) begin
                    m = (1 << MAN) - 1;
                    r_ovf = 1'b1;
                end else begin
                    m = m / 2;
                    e = le + 1;
                end
            end
        end else if (lm >= sm) begin
            m = lm - sm;
        end else begin
            m = sm - lm;
            s = ss;
        end
        if (m == 0) begin
            s = 1'b0;
            e = -(1 << (EXP - 1));
        end
        ev  = e[EXP-1:0];
        mv  = m[MAN-1:0];
        r   = {s, ev, mv};
        lat = cnt + 2;
    endfunction

    // Output monitor: every cycle with out_valid, the held word must match the queue head.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: actual %0h required no result", out);
            end else begin
                check("out", out, exp_q[0]);
                check("ovf", ovf, ovf_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(ovf_q.pop_front());
                end
            end
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o, input int hold);
        logic [W-1:0] r;
        logic         rv;
        int           lat, n;
        model(x, y, o, r, rv, lat);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_idle", in_ready, 1);
        a = x; b = y; op = o; in_valid = 1'b1;
        exp_q.push_back(r);
        ovf_q.push_back(rv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
        check("accept_busy", {in_ready, out_valid, ovf}, 3'b000);
        n = 0;
        while (!out_valid && n < MAN + 10) begin
            @(posedge clk); #1; n++;
        end
        check("latency", n, lat);
        if (!out_valid) begin
            exp_q.delete();
            ovf_q.delete();
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_out", out, r);
            check("hold_flags", {out_valid, in_ready, ovf}, {2'b10, rv});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("after_take", {out_valid, in_ready}, 2'b01);
        check("out_retained", out, r);
    endtask

    logic [W-1:0] one, half, r;
    logic         rv;
    int           lat;

    initial begin
        one  = mk(1'b0, 8'hEA, 23'h400000);
        half = mk(1'b0, 8'hE9, 23'h400000);

        // Pin the reference model on hand-computed cases.
        model(one, one, 1'b0, r, rv, lat);
        check("model_carry", {r, rv, 8'(lat)}, {mk(1'b0, 8'hEB, 23'h400000), 1'b0, 8'd2});
        model(one, half, 1'b1, r, rv, lat);
        check("model_sub", {r, 8'(lat)}, {mk(1'b0, 8'hEA, 23'h200000), 8'd3});
        model(one, mk(1'b0, 8'hC2, 23'h400000), 1'b0, r, rv, lat);
        check("model_gap", {r, 8'(lat)}, {one, 8'd25});
        model(one, one, 1'b1, r, rv, lat);
        check("model_cancel", r, mk(1'b0, 8'h80, 23'h0));
        model(mk(1'b1, 8'hEA, 23'h400000), mk(1'b0, 8'hEA, 23'h100000), 1'b0, r, rv, lat);
        check("model_sign", r, mk(1'b1, 8'hEA, 23'h300000));
        model(mk(1'b0, 8'h7F, 23'h7FFFFF), mk(1'b0, 8'h7F, 23'h7FFFFF), 1'b0, r, rv, lat);
        check("model_sat", {r, rv}, {mk(1'b0, 8'h7F, 23'h7FFFFF), 1'b1});

        // Reset state.
        #2 rst = 1'b0;
        #10;
        check("reset_state", {in_ready, out_valid, ovf, out}, {3'b100, {W{1'b0}}});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the test plan.
        do_op(one, one, 1'b0, 0);
        do_op(one, half, 1'b1, 1);
        do_op(one, mk(1'b0, 8'hC2, 23'h400000), 1'b0, 0);
        do_op(one, mk(1'b0, 8'h80, 23'h0), 1'b0, 0);
        do_op(one, one, 1'b1, 0);
        do_op(mk(1'b1, 8'hEA, 23'h400000), mk(1'b0, 8'hEA, 23'h100000), 1'b0, 0);
        do_op(mk(1'b0, 8'h7F, 23'h7FFFFF), mk(1'b0, 8'h7F, 23'h7FFFFF), 1'b0, 5);
        do_op(half, one, 1'b0, 0);

        // Reset in the middle of a d=10 alignment.
        a = one; b = mk(1'b0, 8'hE0, 23'h400000); op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_reset", {in_ready, out_valid, ovf, out}, {3'b100, {W{1'b0}}});
        #2 rst = 1'b1;
        @(posedge clk); #1;
        do_op(one, mk(1'b0, 8'hE0, 23'h400000), 1'b0, 0);

        // Randomized operands with clustered exponents to exercise alignment.
        for (int i = 0; i < 150; i++) begin
            logic [EXP-1:0] ea, eb;
            logic [W-1:0]   x, y;
            ea = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ea = 8'h7F;
            eb = ($urandom_range(0, 1) == 1) ? ea + 8'($urandom_range(0, 30))
                                              : ea - 8'($urandom_range(0, 30));
            x = mk(1'($urandom_range(0, 1)), ea, 23'($urandom));
            y = mk(1'($urandom_range(0, 1)), eb, 23'($urandom));
            if ($urandom_range(0, 9) == 0) y = mk(1'b0, 8'h80, 23'h0);
            if ($urandom_range(0, 9) == 0) y = x;
            do_op(x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
